// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for active-low seven-segment digits on a shared segment bus.
// Values are double-buffered so a frame never tears; a dead gap before each digit prevents ghosting.
module display_scan_controller #(
    parameter int NUM_DISPLAYS = 2,
    parameter int DIGIT_CYCLES = 4,
    parameter int DEAD_CYCLES  = 1
) (
    input  logic                                                      clk,
    input  logic                                                      reset,
    input  logic                                                      enable,
    input  logic [NUM_DISPLAYS-1:0][3:0]                              value,
    input  logic                                                      load,
    input  logic                                                      lz_en,
    output logic [6:0]                                                seg,
    output logic [NUM_DISPLAYS-1:0]                                   an,
    output logic [((NUM_DISPLAYS > 1) ? $clog2(NUM_DISPLAYS) : 1)-1:0] digit_sel,
    output logic                                                      frame_done
);

    localparam int SEL_W   = (NUM_DISPLAYS > 1) ? $clog2(NUM_DISPLAYS) : 1;
    localparam int MAX_CYC = (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_DISPLAYS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DEAD  = 2'd1;
    localparam logic [1:0] S_ON    = 2'd2;
    localparam logic [1:0] S_FIRST = (DEAD_CYCLES > 0) ? S_DEAD : S_ON;

    logic [1:0]                    state, state_n;
    logic [CNT_W-1:0]              cnt, cnt_n;
    logic [SEL_W-1:0]              sel_n;
    logic [NUM_DISPLAYS-1:0][3:0]  pending, active, active_n;
    logic                          frame_start;
    logic [3:0]                    digit_val;
    logic                          blank, nonzero_above, lit;
    logic [6:0]                    seg_n;
    logic [NUM_DISPLAYS-1:0]       an_n;
    logic                          frame_done_n;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        sel_n       = digit_sel;
        frame_start = 1'b0;
        if (!enable) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            sel_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    frame_start = 1'b1;
                    state_n     = S_FIRST;
                    cnt_n       = '0;
                    sel_n       = '0;
                end
                S_DEAD: begin
                    if (cnt == DEAD_LAST) begin
                        state_n = S_ON;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (cnt == DIGIT_LAST) begin
                        state_n = S_FIRST;
                        cnt_n   = '0;
                        if (digit_sel == SEL_LAST) begin
                            sel_n       = '0;
                            frame_start = 1'b1;
                        end else begin
                            sel_n = digit_sel + SEL_W'(1);
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    sel_n   = '0;
                end
            endcase
        end
    end

    // Outputs are derived from the next-cycle view so the registered pins line up with the state.
    always_comb begin
        active_n      = frame_start ? pending : active;
        digit_val     = '0;
        blank         = 1'b0;
        nonzero_above = 1'b0;
        for (int i = NUM_DISPLAYS - 1; i >= 0; i--) begin
            nonzero_above = nonzero_above | (active_n[i] != 4'd0);
            if (sel_n == SEL_W'(i)) begin
                digit_val = active_n[i];
                blank     = lz_en && (i != 0) && !nonzero_above;
            end
        end
        lit  = (state_n == S_ON) && !blank;
        an_n = '1;
        for (int i = 0; i < NUM_DISPLAYS; i++) begin
            if (lit && (sel_n == SEL_W'(i))) an_n[i] = 1'b0;
        end
        seg_n        = lit ? decode(digit_val) : 7'h7F;
        frame_done_n = (state_n == S_ON) && (sel_n == SEL_LAST) && (cnt_n == DIGIT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            digit_sel  <= '0;
            pending    <= '0;
            active     <= '0;
            seg        <= 7'h7F;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            digit_sel  <= sel_n;
            active     <= active_n;
            seg        <= seg_n;
            an         <= an_n;
            frame_done <= frame_done_n;
            if (load) pending <= value;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized bench for display_scan_controller: two instances (2 digits with dead gap, 3 digits without)
// checked every cycle against a frame-position model of the scan.
module tb_display_scan_controller;

    logic             clk = 1'b0;
    logic             reset, enable, load, lz_en;
    logic [2:0][3:0]  value;

    logic [6:0] seg_a, seg_b;
    logic [1:0] an_a;
    logic [2:0] an_b;
    logic [0:0] sel_a;
    logic [1:0] sel_b;
    logic       fd_a, fd_b;

    int vectors     = 0;
    int miscompares = 0;

    bit         run_m  [2];
    int         t_m    [2];
    logic [3:0] pend_m [2][3];
    logic [3:0] act_m  [2][3];

    always #5 clk = ~clk;

    display_scan_controller #(.NUM_DISPLAYS(2), .DIGIT_CYCLES(4), .DEAD_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .value(value[1:0]), .load(load), .lz_en(lz_en),
        .seg(seg_a), .an(an_a), .digit_sel(sel_a), .frame_done(fd_a)
    );

    display_scan_controller #(.NUM_DISPLAYS(3), .DIGIT_CYCLES(4), .DEAD_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .value(value), .load(load), .lz_en(lz_en),
        .seg(seg_b), .an(an_b), .digit_sel(sel_b), .frame_done(fd_b)
    );

    function automatic logic [6:0] seven_seg(input logic [3:0] d);
        logic [6:0] tab [16];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return tab[d];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    // Model tracks position t within the frame; active snapshots pending whenever a frame begins.
    task automatic model_step(input int k, input int n, input int dead, input int dig,
                              input bit rst, input bit en, input bit ld, input logic [2:0][3:0] val);
        int period;
        period = n * (dead + dig);
        if (rst) begin
            run_m[k] = 1'b0;
            t_m[k]   = 0;
            for (int j = 0; j < 3; j++) begin
                pend_m[k][j] = 4'd0;
                act_m[k][j]  = 4'd0;
            end
        end else begin
            if (!en) begin
                run_m[k] = 1'b0;
                t_m[k]   = 0;
            end else if (!run_m[k]) begin
                run_m[k] = 1'b1;
                t_m[k]   = 0;
                for (int j = 0; j < n; j++) act_m[k][j] = pend_m[k][j];
            end else begin
                t_m[k] = (t_m[k] + 1) % period;
                if (t_m[k] == 0)
                    for (int j = 0; j < n; j++) act_m[k][j] = pend_m[k][j];
            end
            if (ld)
                for (int j = 0; j < n; j++) pend_m[k][j] = val[j];
        end
    endtask

    task automatic check_instance(input int k, input int n, input int dead, input int dig, input bit lz,
                                  input string pfx, input logic [6:0] seg_o, input logic [2:0] an_o,
                                  input logic [1:0] sel_o, input logic fd_o);
        int slot, off, len;
        bit blank;
        logic [6:0] exp_seg;
        logic [2:0] exp_an;
        logic [1:0] exp_sel;
        logic       exp_fd;
        exp_seg = 7'h7F;
        exp_an  = 3'((1 << n) - 1);
        exp_sel = 2'd0;
        exp_fd  = 1'b0;
        if (run_m[k]) begin
            len     = dead + dig;
            slot    = t_m[k] / len;
            off     = t_m[k] % len;
            exp_sel = 2'(slot);
            if (off >= dead) begin
                blank = lz && (slot > 0);
                for (int j = slot; j < n; j++)
                    if (act_m[k][j] != 4'd0) blank = 1'b0;
                if (!blank) begin
                    exp_an  = 3'(((1 << n) - 1) & ~(1 << slot));
                    exp_seg = seven_seg(act_m[k][slot]);
                end
                exp_fd = (slot == n - 1) && (off == len - 1);
            end
        end
        check_output({pfx, "_seg"}, 32'(seg_o), 32'(exp_seg));
        check_output({pfx, "_an"}, 32'(an_o), 32'(exp_an));
        check_output({pfx, "_digit_sel"}, 32'(sel_o), 32'(exp_sel));
        check_output({pfx, "_frame_done"}, 32'(fd_o), 32'(exp_fd));
    endtask

    task automatic apply_stimulus(input bit r, input bit en, input bit ld, input bit lz,
                                  input logic [2:0][3:0] v);
        reset  = r;
        enable = en;
        load   = ld;
        lz_en  = lz;
        value  = v;
        @(posedge clk);
        model_step(0, 2, 1, 4, r, en, ld, v);
        model_step(1, 3, 0, 4, r, en, ld, v);
        #1;
        check_instance(0, 2, 1, 4, lz, "a", seg_a, {1'b0, an_a}, {1'b0, sel_a}, fd_a);
        check_instance(1, 3, 0, 4, lz, "b", seg_b, an_b, sel_b, fd_b);
    endtask

    function automatic logic [2:0][3:0] rand_value();
        logic [2:0][3:0] v;
        for (int j = 0; j < 3; j++)
            v[j] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
        return v;
    endfunction

    initial begin
        bit lz_r, en_r;
        reset  = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        lz_en  = 1'b0;
        value  = '0;
        for (int k = 0; k < 2; k++) begin
            run_m[k] = 1'b0;
            t_m[k]   = 0;
            for (int j = 0; j < 3; j++) begin
                pend_m[k][j] = 4'd0;
                act_m[k][j]  = 4'd0;
            end
        end

        repeat (2) apply_stimulus(1, 0, 0, 0, '0);
        repeat (3) apply_stimulus(0, 0, 0, 0, '0);

        apply_stimulus(0, 0, 1, 0, {4'h0, 4'h1, 4'h8});
        repeat (6) apply_stimulus(0, 1, 0, 0, '0);
        apply_stimulus(0, 1, 1, 0, {4'h3, 4'h2, 4'hF});
        repeat (24) apply_stimulus(0, 1, 0, 0, '0);

        apply_stimulus(0, 1, 1, 1, {4'h0, 4'h0, 4'h5});
        repeat (24) apply_stimulus(0, 1, 0, 1, '0);
        apply_stimulus(0, 1, 1, 1, {4'h0, 4'h0, 4'h0});
        repeat (24) apply_stimulus(0, 1, 0, 1, '0);

        apply_stimulus(0, 1, 1, 0, {4'hA, 4'hB, 4'hC});
        repeat (17) apply_stimulus(0, 1, 0, 0, '0);
        apply_stimulus(0, 0, 0, 0, '0);
        repeat (12) apply_stimulus(0, 1, 0, 0, '0);
        apply_stimulus(1, 1, 1, 0, {4'h7, 4'h7, 4'h7});
        repeat (25) apply_stimulus(0, 1, 0, 0, '0);

        lz_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(49) == 0) lz_r = ~lz_r;
            en_r = ($urandom_range(39) != 0);
            apply_stimulus(($urandom_range(199) == 0), en_r, ($urandom_range(9) == 0), lz_r, rand_value());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
